// File: rtl/fifo_put_arbiter.sv
// Round-robin arbiter sharing the FIFO put port among N_REQ producers.
// Bursts of up to MAX_BURST words per grant, stalls cleanly on full_out.
module fifo_put_arbiter #(
    parameter int N_BITS    = 32,
    parameter int N_REQ     = 4,
    parameter int MAX_BURST = 4
) (
    input  logic                       clk_put,
    input  logic                       reset,
    input  logic [N_REQ-1:0]           req,
    input  logic [N_REQ*N_BITS-1:0]    data_in,
    input  logic                       full_out,
    output logic [N_REQ-1:0]           grant,
    output logic                       req_put,
    output logic [N_BITS-1:0]          data_put,
    output logic [N_REQ-1:0]           ack,
    output logic [$clog2(N_REQ)-1:0]   owner,
    output logic                       busy
);

    localparam int IW  = $clog2(N_REQ);
    localparam int IWP = IW + 1;

    typedef enum logic {IDLE, OWN} state_t;

    state_t           state_q, state_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic [IW-1:0]    owner_q, owner_d;
    logic [IW-1:0]    rr_ptr_q, rr_ptr_d;
    logic [3:0]       burst_cnt_q, burst_cnt_d;

    logic             ack_any;
    logic             burst_end;
    logic             rel;
    logic [IW-1:0]    next_ptr;
    logic [N_REQ-1:0] owner_oh;
    logic [N_REQ-1:0] others;
    logic [N_REQ-1:0] cand;
    logic [IW:0]      idle_hit;
    logic [IW:0]      hand_hit;

    // First set bit of m searching upward from p, wrapping mod N_REQ.
    // Returns {found, index}.
    function automatic logic [IW:0] pick(
        input logic [N_REQ-1:0] m,
        input logic [IW-1:0]    p
    );
        logic [IW:0] r;
        logic [IW:0] s;
        r = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            s = {1'b0, p} + IWP'(k);
            if (s >= IWP'(N_REQ)) begin
                s = s - IWP'(N_REQ);
            end
            if (m[s[IW-1:0]]) begin
                r = {1'b1, s[IW-1:0]};
            end
        end
        return r;
    endfunction

    assign ack     = grant_q & req & {N_REQ{~full_out}};
    assign req_put = |ack;
    assign grant   = grant_q;
    assign owner   = owner_q;
    assign busy    = |grant_q;

    always_comb begin
        data_put = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant_q[i]) begin
                data_put = data_put | data_in[i*N_BITS +: N_BITS];
            end
        end
    end

    always_comb begin
        ack_any   = |ack;
        owner_oh  = N_REQ'(1) << owner_q;
        burst_end = ack_any && (burst_cnt_q == 4'(MAX_BURST - 1));
        rel       = (state_q == OWN) && (burst_end || !req[owner_q]);
        next_ptr  = (owner_q == IW'(N_REQ - 1)) ? '0 : owner_q + 1'b1;
        others    = req & ~owner_oh;
        // After a full burst the owner yields unless nobody else wants the port.
        cand      = (burst_end && (others != '0)) ? others : req;
        idle_hit  = pick(req, rr_ptr_q);
        hand_hit  = pick(cand, next_ptr);

        state_d     = state_q;
        grant_d     = grant_q;
        owner_d     = owner_q;
        rr_ptr_d    = rr_ptr_q;
        burst_cnt_d = burst_cnt_q;

        unique case (state_q)
            IDLE: begin
                if (idle_hit[IW]) begin
                    state_d     = OWN;
                    owner_d     = idle_hit[IW-1:0];
                    grant_d     = N_REQ'(1) << idle_hit[IW-1:0];
                    burst_cnt_d = '0;
                end
            end
            OWN: begin
                if (rel) begin
                    rr_ptr_d    = next_ptr;
                    burst_cnt_d = '0;
                    if (hand_hit[IW]) begin
                        owner_d = hand_hit[IW-1:0];
                        grant_d = N_REQ'(1) << hand_hit[IW-1:0];
                    end else begin
                        state_d = IDLE;
                        grant_d = '0;
                    end
                end else if (ack_any) begin
                    burst_cnt_d = burst_cnt_q + 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk_put) begin
        if (reset) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            owner_q     <= '0;
            rr_ptr_q    <= '0;
            burst_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            owner_q     <= owner_d;
            rr_ptr_q    <= rr_ptr_d;
            burst_cnt_q <= burst_cnt_d;
        end
    end

endmodule

// File: tb/tb_fifo_put_arbiter.sv
// Bench for fifo_put_arbiter: vector table, hand sequences for
// rotation and stall, then random traffic against a reference model.
module tb_fifo_put_arbiter;

    localparam int NB = 32;
    localparam int NR = 4;
    localparam int MB = 4;

    logic            clk_put = 1'b0;
    logic            reset   = 1'b1;
    logic [NR-1:0]   req     = '0;
    logic [NR*NB-1:0] data_in = '0;
    logic            full_out = 1'b0;
    logic [NR-1:0]   grant;
    logic            req_put;
    logic [NB-1:0]   data_put;
    logic [NR-1:0]   ack;
    logic [1:0]      owner;
    logic            busy;

    int n_tests = 0;
    int n_fail  = 0;

    fifo_put_arbiter #(.N_BITS(NB), .N_REQ(NR), .MAX_BURST(MB)) dut (
        .clk_put (clk_put),
        .reset   (reset),
        .req     (req),
        .data_in (data_in),
        .full_out(full_out),
        .grant   (grant),
        .req_put (req_put),
        .data_put(data_put),
        .ack     (ack),
        .owner   (owner),
        .busy    (busy)
    );

    always #5 clk_put = ~clk_put;

    typedef struct {
        logic          rst;
        logic [NR-1:0] rq;
        logic          full;
        logic [NR-1:0] g;
        logic [NR-1:0] a;
        logic [1:0]    o;
    } vec_t;

    vec_t tbl[23];

    // Model state: busy flag, owner, round-robin pointer, words in burst.
    int mb, mo, mp, mc;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [NB-1:0] slice_of(input logic [NR-1:0] g);
        logic [NB-1:0] d;
        d = '0;
        for (int i = 0; i < NR; i++)
            if (g[i]) d = data_in[i*NB +: NB];
        return d;
    endfunction

    function automatic logic [63:0] act_pack();
        return 64'({grant, ack, req_put, owner, busy, data_put});
    endfunction

    function automatic logic [63:0] exp_pack(input logic [NR-1:0] g,
                                             input logic [NR-1:0] a,
                                             input logic [1:0] o);
        return 64'({g, a, |a, o, |g, slice_of(g)});
    endfunction

    function automatic int first_from(input logic [NR-1:0] m, input int p);
        for (int k = 0; k < NR; k++)
            if (m[(p + k) % NR]) return (p + k) % NR;
        return -1;
    endfunction

    task automatic model_step();
        logic took, done;
        logic [NR-1:0] cnd, oth;
        if (reset) begin
            mb = 0; mo = 0; mp = 0; mc = 0;
        end else if (mb == 0) begin
            if (req != '0) begin
                mo = first_from(req, mp); mc = 0; mb = 1;
            end
        end else begin
            took = req[mo] && !full_out;
            if (took) mc++;
            done = took && (mc == MB);
            if (done || !req[mo]) begin
                mp  = (mo + 1) % NR;
                oth = req & ~(NR'(1) << mo);
                cnd = (done && oth != '0) ? oth : req;
                mc  = 0;
                if (cnd != '0) mo = first_from(cnd, mp);
                else mb = 0;
            end
        end
    endtask

    task automatic next_cycle();
        @(posedge clk_put);
        #1;
    endtask

    initial begin
        logic [NR-1:0] eg, ea;
        int order[4];
        order = '{0, 1, 3, 0};

        tbl[0]  = '{1'b1, 4'b1111, 1'b0, 4'b0000, 4'b0000, 2'd0};
        tbl[1]  = '{1'b1, 4'b1111, 1'b0, 4'b0000, 4'b0000, 2'd0};
        tbl[2]  = '{1'b1, 4'b1111, 1'b0, 4'b0000, 4'b0000, 2'd0};
        tbl[3]  = '{1'b0, 4'b0100, 1'b0, 4'b0000, 4'b0000, 2'd0};
        tbl[4]  = '{1'b0, 4'b0100, 1'b0, 4'b0100, 4'b0100, 2'd2};
        tbl[5]  = '{1'b0, 4'b0100, 1'b0, 4'b0100, 4'b0100, 2'd2};
        tbl[6]  = '{1'b0, 4'b0100, 1'b0, 4'b0100, 4'b0100, 2'd2};
        tbl[7]  = '{1'b0, 4'b0100, 1'b0, 4'b0100, 4'b0100, 2'd2};
        tbl[8]  = '{1'b0, 4'b0100, 1'b0, 4'b0100, 4'b0100, 2'd2};
        tbl[9]  = '{1'b0, 4'b0000, 1'b0, 4'b0100, 4'b0000, 2'd2};
        tbl[10] = '{1'b0, 4'b0001, 1'b0, 4'b0000, 4'b0000, 2'd2};
        tbl[11] = '{1'b0, 4'b1001, 1'b0, 4'b0001, 4'b0001, 2'd0};
        tbl[12] = '{1'b0, 4'b1000, 1'b0, 4'b0001, 4'b0000, 2'd0};
        tbl[13] = '{1'b0, 4'b1000, 1'b0, 4'b1000, 4'b1000, 2'd3};
        tbl[14] = '{1'b0, 4'b1001, 1'b0, 4'b1000, 4'b1000, 2'd3};
        tbl[15] = '{1'b0, 4'b0001, 1'b0, 4'b1000, 4'b0000, 2'd3};
        tbl[16] = '{1'b0, 4'b1001, 1'b0, 4'b0001, 4'b0001, 2'd0};
        tbl[17] = '{1'b0, 4'b1000, 1'b1, 4'b0001, 4'b0000, 2'd0};
        tbl[18] = '{1'b0, 4'b1000, 1'b1, 4'b1000, 4'b0000, 2'd3};
        tbl[19] = '{1'b0, 4'b1000, 1'b0, 4'b1000, 4'b1000, 2'd3};
        tbl[20] = '{1'b1, 4'b1000, 1'b0, 4'b1000, 4'b1000, 2'd3};
        tbl[21] = '{1'b0, 4'b1001, 1'b0, 4'b0000, 4'b0000, 2'd0};
        tbl[22] = '{1'b0, 4'b1001, 1'b0, 4'b0001, 4'b0001, 2'd0};

        for (int i = 0; i < NR; i++)
            data_in[i*NB +: NB] = 32'hA000_0000 + 32'(i);

        reset = 1'b1;
        repeat (2) next_cycle();

        for (int v = 0; v < 23; v++) begin
            reset    = tbl[v].rst;
            req      = tbl[v].rq;
            full_out = tbl[v].full;
            @(negedge clk_put);
            chk($sformatf("vec%0d", v), act_pack(),
                exp_pack(tbl[v].g, tbl[v].a, tbl[v].o));
            next_cycle();
        end

        // Round robin over 1011: owners 0,1,3,0, four words each.
        reset = 1'b1; req = 4'b1011; full_out = 1'b0;
        next_cycle();
        reset = 1'b0;
        @(negedge clk_put);
        chk("rr_idle", act_pack(), exp_pack(4'b0000, 4'b0000, 2'd0));
        next_cycle();
        for (int w = 0; w < 16; w++) begin
            eg = NR'(1) << order[w / 4];
            @(negedge clk_put);
            chk($sformatf("rr_word%0d", w), act_pack(),
                exp_pack(eg, eg, 2'(order[w / 4])));
            next_cycle();
        end

        // Stall: owner 1 after two words, full for five cycles.
        reset = 1'b1; req = 4'b0010;
        next_cycle();
        reset = 1'b0;
        next_cycle();
        req = 4'b0011;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk_put);
            chk($sformatf("stall_pre%0d", c), act_pack(),
                exp_pack(4'b0010, 4'b0010, 2'd1));
            next_cycle();
        end
        full_out = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk_put);
            chk($sformatf("stall_full%0d", c), act_pack(),
                exp_pack(4'b0010, 4'b0000, 2'd1));
            next_cycle();
        end
        full_out = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk_put);
            chk($sformatf("stall_post%0d", c), act_pack(),
                exp_pack(4'b0010, 4'b0010, 2'd1));
            next_cycle();
        end
        @(negedge clk_put);
        chk("stall_rotate", act_pack(), exp_pack(4'b0001, 4'b0001, 2'd0));
        next_cycle();

        // Random traffic against the model.
        reset = 1'b1;
        next_cycle();
        mb = 0; mo = 0; mp = 0; mc = 0;
        for (int c = 0; c < 3000; c++) begin
            reset = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 3) == 0) req = NR'($urandom);
            full_out = ($urandom_range(0, 3) == 0);
            for (int i = 0; i < NR; i++)
                data_in[i*NB +: NB] = $urandom;
            eg = (mb != 0) ? NR'(1) << mo : '0;
            ea = eg & req & {NR{~full_out}};
            @(negedge clk_put);
            chk($sformatf("rand%0d", c), act_pack(), exp_pack(eg, ea, 2'(mo)));
            @(posedge clk_put);
            model_step();
            #1;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
